pc16_stack: RTL

PC16_STACK -- requirements
Module: pc16_stack

---
 rtl/pc16_stack.sv | 112 +++++++++++
 1 files changed

// File: rtl/pc16_stack.sv
// rtl/pc16_stack.sv - 16-bit program counter with a small LIFO return-address stack.

module inc16 (
    input  logic [15:0] a,
    output logic [15:0] y,
    output logic        co
);
    assign {co, y} = {1'b0, a} + 17'd1;
endmodule

module pc16_stack #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        inc,
    input  logic        call,
    input  logic        ret,
    output logic [15:0] out,
    output logic        wrap,
    output logic        stk_empty,
    output logic        stk_full,
    output logic        stk_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [CW-1:0] count_m1;
    logic [15:0]   mem [DEPTH];
    logic [15:0]   out_plus1;
    logic          carry;
    logic [15:0]   out_next;
    logic          wrap_next;
    logic          err_next;
    logic          is_empty;
    logic          is_full;
    logic          do_push;
    logic          do_pop;
    logic [AW-1:0] push_idx;
    logic [AW-1:0] pop_idx;

    inc16 u_inc (
        .a  (out),
        .y  (out_plus1),
        .co (carry)
    );

    assign count_m1 = count - CW'(1);
    assign push_idx = count[AW-1:0];
    assign pop_idx  = count_m1[AW-1:0];
    assign is_empty = (count == '0);
    assign is_full  = (count == CW'(DEPTH));
    assign do_pop   = ret && !is_empty;
    assign do_push  = !ret && call && !is_full;

    // Priority ret > call > load > inc; a rejected ret/call still blocks the lower requests.
    always_comb begin
        out_next   = out;
        wrap_next  = 1'b0;
        err_next   = 1'b0;
        count_next = count;
        if (ret) begin
            if (is_empty) begin
                err_next = 1'b1;
            end else begin
                out_next   = mem[pop_idx];
                count_next = count_m1;
            end
        end else if (call) begin
            if (is_full) begin
                err_next = 1'b1;
            end else begin
                out_next   = in;
                count_next = count + CW'(1);
            end
        end else if (load) begin
            out_next = in;
        end else if (inc) begin
            out_next  = out_plus1;
            wrap_next = carry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= 16'h0000;
            count     <= '0;
            wrap      <= 1'b0;
            stk_err   <= 1'b0;
            stk_empty <= 1'b1;
            stk_full  <= 1'b0;
        end else begin
            out       <= out_next;
            count     <= count_next;
            wrap      <= wrap_next;
            stk_err   <= err_next;
            stk_empty <= (count_next == '0);
            stk_full  <= (count_next == CW'(DEPTH));
        end
    end

    // Entry storage is never reset; entries above count are unreachable.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[push_idx] <= out_plus1;
        end
    end
endmodule
